fpro_mmio_arbiter: RTL and testbench
====================================

Name: fpro_mmio_arbiter

Overview:
- Two-master arbiter in front of the FPro MMIO bus (mmio_cs/wr/rd/addr/wr_data/rd_data) that feeds the mmio subsystem.
- Master 0 is the MCS bridge path. Master 1 is a hardware master, such as a sampler-capture sequencer or a DMA engine.
- Sequences one single-beat transaction at a time with a req/ack handshake, registers read data back to the winning master, and enforces a selectable round-robin or fixed-priority policy with a starvation guard.

Parameters:
- ADDR_W, 21, MMIO address width (matches fp_addr).
- DATA_W, 32, data width.
- RR_EN, 1, 1 = round-robin; 0 = fixed priority M0 over M1 with starvation guard.
- MAX_BURST, 4, fixed-priority mode only: max consecutive M0 grants while M1 waits (legal range 1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_req  in  1  M0 request; held with command until m0_ack
- m0_wr  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  M0 address
- m0_wr_data  in  DATA_W  M0 write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rd_data  out  DATA_W  read data, valid with m0_ack on reads
- m1_req, m1_wr, m1_addr, m1_wr_data, m1_ack, m1_rd_data: same as M0, for master 1
- mmio_cs  out  1  slave select
- mmio_wr  out  1  write strobe
- mmio_rd  out  1  read strobe
- mmio_addr  out  ADDR_W  slave address
- mmio_wr_data  out  DATA_W  slave write data
- mmio_rd_data  in  DATA_W  slave read data, combinational in the same cycle as mmio_rd
- busy  out  1  high in ISSUE and RESP
- gnt_id  out  1  master owning the current or most recent transaction

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE; all mmio_* outputs, acks, rd_data, busy and burst_cnt = 0.
  - last_gnt = 1, so M0 wins the first tie; gnt_id = 0.
- FSM IDLE:
  - No req: stay in IDLE.
  - Any req: choose winner, latch winner's wr/addr/wr_data into internal registers, set gnt_id, go to ISSUE.
- FSM ISSUE (exactly 1 cycle):
  - mmio_cs = 1; mmio_wr = latched wr; mmio_rd = !latched wr; addr/wr_data driven from latched registers.
  - On a read, capture mmio_rd_data into the winner's rd_data register at the end of the cycle.
  - Go to RESP.
- FSM RESP (exactly 1 cycle): winner's ack = 1; mmio_* = 0; go to IDLE.
- Latency: req sampled in IDLE at cycle 0, bus strobe at cycle 1, ack plus valid data at cycle 2. Back-to-back throughput is one transaction per 3 cycles.
- mmio_cs, mmio_wr and mmio_rd are registered outputs: glitch-free and never high outside ISSUE.
- Non-winning master's ack stays 0. Its rd_data holds its last read value, as does the winner's on a write.
- Round-robin (RR_EN=1):
  - Both requesting: grant the master != last_gnt.
  - Single requester: always granted.
  - last_gnt updates on every grant.
- Fixed priority (RR_EN=0):
  - M0 wins ties unless burst_cnt == MAX_BURST, in which case M1 is granted.
  - burst_cnt increments on each M0 grant made while m1_req = 1, saturating at MAX_BURST.
  - burst_cnt clears on any M1 grant, or on any M0 grant while m1_req = 0.
- Command is latched at grant. Changes to a master's req/wr/addr/data after the grant do not affect the in-flight transaction.
- A req dropped before ack is a protocol violation. The latched transaction still completes and ack is still pulsed.
- A master holding req high in the cycle after its ack has that cycle treated as a new request.
- reset_n asserted mid-transaction: immediate return to IDLE with all strobes and acks low. No ack is issued for the aborted transaction.
- Address and data pass through unmodified; no decoding is done here.

Test Plan:
- M0 write only (addr=0x00010, data=0xDEADBEEF) -> mmio_wr=1 and mmio_cs=1 for exactly 1 cycle, 1 cycle after req; m0_ack at cycle 2; m1_ack stays 0.
- M1 read of addr 0x00204, slave returns 0xA5A5_0001 -> m1_rd_data = 0xA5A50001 with m1_ack at cycle 2; mmio_rd high exactly 1 cycle.
- RR_EN=1, both reqs held continuously for 6 transactions -> grant order 0,1,0,1,0,1; each ack pulses once per grant; gnt_id tracks the grant order.
- RR_EN=0, MAX_BURST=4, both reqs held -> grant order 0,0,0,0,1,0,0,0,0,1; with m1_req low, M0 gets 10 straight grants and M1 is never granted.
- M0 changes m0_addr from 0x10 to 0x20 during ISSUE -> mmio_addr stays 0x10 for that transaction.
- reset_n pulled low during ISSUE -> mmio_cs/wr/rd drop asynchronously; no ack occurs; after release the first request is serviced normally with M0 winning a tie.

Source files
------------

// File: rtl/fpro_mmio_arbiter.sv
// Two-master arbiter in front of the FPro MMIO bus.
// Runs one single-beat transaction at a time: IDLE (arbitrate and latch the
// command) -> ISSUE (one-cycle bus strobe) -> RESP (one-cycle ack to the winner).
// The policy is either round-robin or fixed priority (M0 over M1). Fixed
// priority limits how many grants M0 can take in a row while M1 is waiting.
module fpro_mmio_arbiter #(
  parameter int ADDR_W    = 21,
  parameter int DATA_W    = 32,
  parameter int RR_EN     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data,
  output logic              busy,
  output logic              gnt_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_t     state;
  logic       last_gnt;
  logic [3:0] burst_cnt;
  logic       win;

  // Pick the winner among the current requesters; only used when one exists.
  always_comb begin
    win = 1'b0;
    if (RR_EN != 0) begin
      if (m0_req && m1_req) win = ~last_gnt;
      else                  win = m1_req;
    end else begin
      if (m0_req && !(m1_req && burst_cnt == BURST_MAX)) win = 1'b0;
      else                                               win = m1_req;
    end
  end

  // A strobe can only be high in ISSUE, so busy decodes straight from state.
  assign busy = (state != IDLE);

  // Transaction FSM. The bus registers also hold the latched command, so
  // changes on a master's inputs after the grant cannot reach the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_gnt     <= 1'b1;
      gnt_id       <= 1'b0;
      burst_cnt    <= '0;
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rd_data   <= '0;
      m1_rd_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state        <= ISSUE;
            gnt_id       <= win;
            last_gnt     <= win;
            mmio_cs      <= 1'b1;
            mmio_wr      <= win ? m1_wr : m0_wr;
            mmio_rd      <= ~(win ? m1_wr : m0_wr);
            mmio_addr    <= win ? m1_addr : m0_addr;
            mmio_wr_data <= win ? m1_wr_data : m0_wr_data;
            // Count M0 grants that made a waiting M1 wait longer.
            if (!win && m1_req)
              burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 4'd1;
            else
              burst_cnt <= '0;
          end
        end
        ISSUE: begin
          state        <= RESP;
          mmio_cs      <= 1'b0;
          mmio_wr      <= 1'b0;
          mmio_rd      <= 1'b0;
          mmio_addr    <= '0;
          mmio_wr_data <= '0;
          if (gnt_id) m1_ack <= 1'b1;
          else        m0_ack <= 1'b1;
          if (mmio_rd) begin
            if (gnt_id) m1_rd_data <= mmio_rd_data;
            else        m0_rd_data <= mmio_rd_data;
          end
        end
        RESP: begin
          state  <= IDLE;
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpro_mmio_arbiter.sv
// Directed bench for fpro_mmio_arbiter. A round-robin instance and a
// fixed-priority instance (MAX_BURST=4) share the same master inputs. Each
// instance has its own simple combinational slave.
module tb_fpro_mmio_arbiter;

  localparam int AW = 21;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wr_data, m1_wr_data;

  logic          r_m0_ack, r_m1_ack, r_cs, r_wr, r_rd, r_busy, r_gnt;
  logic [DW-1:0] r_m0_rd, r_m1_rd, r_wdat, r_rdat;
  logic [AW-1:0] r_addr;
  logic          f_m0_ack, f_m1_ack, f_cs, f_wr, f_rd, f_busy, f_gnt;
  logic [DW-1:0] f_m0_rd, f_m1_rd, f_wdat, f_rdat;
  logic [AW-1:0] f_addr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // The slave returns a fixed value at 0x204 and an address-derived value
  // everywhere else.
  function automatic logic [DW-1:0] slave(input logic [AW-1:0] a);
    return (a == 21'h00204) ? 32'hA5A5_0001 : ({11'b0, a} ^ 32'h1234_0000);
  endfunction

  assign r_rdat = slave(r_addr);
  assign f_rdat = slave(f_addr);

  fpro_mmio_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1), .MAX_BURST(4)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_ack(r_m0_ack), .m0_rd_data(r_m0_rd),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_ack(r_m1_ack), .m1_rd_data(r_m1_rd),
    .mmio_cs(r_cs), .mmio_wr(r_wr), .mmio_rd(r_rd), .mmio_addr(r_addr),
    .mmio_wr_data(r_wdat), .mmio_rd_data(r_rdat), .busy(r_busy), .gnt_id(r_gnt));

  fpro_mmio_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0), .MAX_BURST(4)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_ack(f_m0_ack), .m0_rd_data(f_m0_rd),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_ack(f_m1_ack), .m1_rd_data(f_m1_rd),
    .mmio_cs(f_cs), .mmio_wr(f_wr), .mmio_rd(f_rd), .mmio_addr(f_addr),
    .mmio_wr_data(f_wdat), .mmio_rd_data(f_rdat), .busy(f_busy), .gnt_id(f_gnt));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wr_data = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wr_data = '0;
    #2;
    do_reset();

    // Reset state
    chk("rst_cs",   r_cs,   0);
    chk("rst_busy", r_busy, 0);
    chk("rst_gnt",  r_gnt,  0);
    chk("rst_ack",  {r_m0_ack, r_m1_ack, f_m0_ack, f_m1_ack}, 0);
    chk("rst_rd",   r_m0_rd | r_m1_rd, 0);
    chk("rst_addr", r_addr, 0);

    // M0 write 0x00010 <- DEADBEEF
    m0_req = 1; m0_wr = 1; m0_addr = 21'h00010; m0_wr_data = 32'hDEADBEEF;
    tick();
    chk("wr_strobe", {r_cs, r_wr, r_rd}, 3'b110);
    chk("wr_addr",   r_addr, 21'h00010);
    chk("wr_data",   r_wdat, 32'hDEADBEEF);
    chk("wr_busy",   r_busy, 1);
    chk("wr_ack_c1", {r_m0_ack, r_m1_ack}, 2'b00);
    tick();
    chk("wr_ack_c2", {r_m0_ack, r_m1_ack}, 2'b10);
    chk("wr_strobe_c2", {r_cs, r_wr, r_rd}, 3'b000);
    m0_req = 0;
    tick();
    chk("wr_ack_c3", {r_m0_ack, r_m1_ack}, 2'b00);
    chk("wr_idle",   r_busy, 0);

    // M1 read of 0x00204
    m1_req = 1; m1_wr = 0; m1_addr = 21'h00204;
    tick();
    chk("rd_strobe", {r_cs, r_wr, r_rd}, 3'b101);
    chk("rd_addr",   r_addr, 21'h00204);
    chk("rd_gnt",    r_gnt, 1);
    tick();
    chk("rd_ack",    {r_m0_ack, r_m1_ack}, 2'b01);
    chk("rd_data",   r_m1_rd, 32'hA5A50001);
    chk("rd_strobe_c2", r_rd, 0);
    m1_req = 0;
    tick();
    chk("rd_hold",   r_m1_rd, 32'hA5A50001);
    chk("rd_m0_hold", r_m0_rd, 0);

    // M0 read: the address changes while the transaction is in ISSUE
    m0_req = 1; m0_wr = 0; m0_addr = 21'h00010;
    tick();
    m0_addr = 21'h00020;
    #3;
    chk("latch_addr", r_addr, 21'h00010);
    tick();
    chk("latch_ack",  r_m0_ack, 1);
    chk("latch_rd",   r_m0_rd, 32'h12340010);
    chk("latch_m1_hold", r_m1_rd, 32'hA5A50001);
    m0_req = 0;
    tick();

    // Both masters request continuously for 10 transactions.
    // Round-robin alternates; fixed priority runs four M0 grants per M1 grant.
    do_reset();
    m0_req = 1; m0_wr = 1; m0_addr = 21'h00100;
    m1_req = 1; m1_wr = 1; m1_addr = 21'h00200;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("rr_gnt%0d", i), r_gnt, (i % 2 == 1));
      chk($sformatf("fp_gnt%0d", i), f_gnt, (i % 5 == 4));
      chk($sformatf("fp_addr%0d", i), f_addr, (i % 5 == 4) ? 21'h00200 : 21'h00100);
      tick();
      chk($sformatf("rr_ack%0d", i), {r_m0_ack, r_m1_ack}, (i % 2 == 1) ? 2'b01 : 2'b10);
      chk($sformatf("fp_ack%0d", i), {f_m0_ack, f_m1_ack}, (i % 5 == 4) ? 2'b01 : 2'b10);
      tick();
    end

    // Only M0 requests: fixed priority grants M0 every time.
    m1_req = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("solo_gnt%0d", i), f_gnt, 0);
      tick();
      chk($sformatf("solo_ack%0d", i), {f_m0_ack, f_m1_ack}, 2'b10);
      tick();
    end

    // Reset during ISSUE. The round-robin instance last granted M0, so it grants M1 now.
    m1_req = 1;
    tick();
    chk("abort_pre_gnt", r_gnt, 1);
    chk("abort_pre_cs",  r_cs, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_strobe",  {r_cs, r_wr, r_rd, f_cs, f_wr, f_rd}, 6'b0);
    chk("abort_busy",    r_busy, 0);
    tick();
    chk("abort_noack",   {r_m0_ack, r_m1_ack, f_m0_ack, f_m1_ack}, 4'b0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_gnt",  r_gnt, 0);
    chk("post_rst_cs",   r_cs, 1);
    tick();
    chk("post_rst_ack",  {r_m0_ack, r_m1_ack}, 2'b10);
    m0_req = 0; m1_req = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
